// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states plus ACK and R/W bit encodings.
// Imported by the target and intended for the bus master as well.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV,
    S_DEV_ACK,
    S_REG,
    S_REG_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } i2c_state_e;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_target_regfile_if.sv
// Local host port of the I2C target register file: read access plus write reports.
interface i2c_target_regfile_if #(
  parameter int REG_AW = 8
);

  logic [REG_AW-1:0] host_addr;
  logic [7:0]        host_rdata;
  logic              wr_valid;
  logic [REG_AW-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output host_addr,
    input  host_rdata, wr_valid, wr_addr, wr_data
  );

  modport slave (
    input  host_addr,
    output host_rdata, wr_valid, wr_addr, wr_data
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into clk and produces START/STOP and SCL edge pulses.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_start,
  output logic o_stop,
  output logic o_scl_rise,
  output logic o_scl_fall
);

  // [1:0] form the synchronizer, [2] is the history flop for edge detection
  logic [2:0] r_scl;
  logic [2:0] r_sda;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl <= '1;
      r_sda <= '1;
    end else begin
      r_scl <= {r_scl[1:0], i_scl};
      r_sda <= {r_sda[1:0], i_sda};
    end
  end

  assign o_sda      = r_sda[1];
  assign o_scl_rise = r_scl[1] & ~r_scl[2];
  assign o_scl_fall = ~r_scl[1] & r_scl[2];
  assign o_start    = r_scl[1] & r_scl[2] & ~r_sda[1] & r_sda[2];
  assign o_stop     = r_scl[1] & r_scl[2] & r_sda[1] & ~r_sda[2];

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with an internal byte register file, pointer-based bus reads/writes
// and a local host read port that also reports every bus-written byte.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h08,
  parameter int         REG_AW      = 8,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe,
  output logic busy,
  i2c_target_regfile_if.slave host
);

  localparam logic [REG_AW-1:0] PTR_ONE = REG_AW'(1);

  logic w_sda, w_start, w_stop, w_rise, w_fall;

  i2c_bus_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_scl      (scl_i),
    .i_sda      (sda_i),
    .o_sda      (w_sda),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_scl_rise (w_rise),
    .o_scl_fall (w_fall)
  );

  i2c_state_e        r_state, w_state_nxt;
  logic [3:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic [REG_AW-1:0] r_ptr, w_ptr_nxt;
  logic              r_rw, w_rw_nxt;
  logic              r_mack, w_mack_nxt;
  logic              r_sda_oe, w_sda_oe_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_wr_valid, w_wr_valid_nxt;
  logic [REG_AW-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [7:0]        r_wr_data, w_wr_data_nxt;
  logic [7:0]        r_regs [2**REG_AW];

  logic [7:0]        w_byte;
  logic [REG_AW-1:0] w_ptr_inc;
  logic [7:0]        w_rd_cur, w_rd_nxt;

  assign w_byte    = {r_shift[6:0], w_sda};
  assign w_ptr_inc = r_ptr + PTR_ONE;
  assign w_rd_cur  = r_regs[r_ptr];
  assign w_rd_nxt  = r_regs[w_ptr_inc];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_ptr      <= '0;
      r_rw       <= RW_WRITE;
      r_mack     <= NACK;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_ptr      <= w_ptr_nxt;
      r_rw       <= w_rw_nxt;
      r_mack     <= w_mack_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_ptr_nxt      = r_ptr;
    w_rw_nxt       = r_rw;
    w_mack_nxt     = r_mack;
    w_sda_oe_nxt   = r_sda_oe;
    w_busy_nxt     = r_busy;
    w_wr_valid_nxt = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;

    if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = S_DEV;
      w_bit_cnt_nxt = '0;
      w_sda_oe_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        S_DEV, S_REG, S_WDATA: begin
          if (w_rise) begin
            w_shift_nxt   = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              if (r_state == S_DEV) begin
                if (w_byte[7:1] == TARGET_ADDR) begin
                  w_state_nxt = S_DEV_ACK;
                  w_busy_nxt  = 1'b1;
                  w_rw_nxt    = w_byte[0];
                end else begin
                  w_state_nxt = S_IGNORE;
                end
              end else if (r_state == S_REG) begin
                w_ptr_nxt   = w_byte[REG_AW-1:0];
                w_state_nxt = S_REG_ACK;
              end else begin
                w_wr_valid_nxt = 1'b1;
                w_wr_addr_nxt  = r_ptr;
                w_wr_data_nxt  = w_byte;
                w_ptr_nxt      = w_ptr_inc;
                w_state_nxt    = S_WDATA_ACK;
              end
            end
          end
        end
        // bit_cnt==8: ACK not yet driven; the 9th SCL rise clears it so the
        // following fall releases SDA and moves on
        S_DEV_ACK, S_REG_ACK, S_WDATA_ACK: begin
          if (w_rise) begin
            w_bit_cnt_nxt = '0;
          end else if (w_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_sda_oe_nxt = ~ACK;
            end else begin
              w_sda_oe_nxt = 1'b0;
              if (r_state == S_DEV_ACK && r_rw == RW_READ) begin
                w_shift_nxt  = w_rd_cur;
                w_sda_oe_nxt = ~w_rd_cur[7];
                w_state_nxt  = S_RDATA;
              end else if (r_state == S_DEV_ACK) begin
                w_state_nxt = S_REG;
              end else begin
                w_state_nxt = S_WDATA;
              end
            end
          end
        end
        S_RDATA: begin
          if (w_rise) begin
            w_shift_nxt   = {r_shift[6:0], 1'b0};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = S_RDATA_ACK;
            end else begin
              w_sda_oe_nxt = ~r_shift[7];
            end
          end
        end
        S_RDATA_ACK: begin
          if (w_rise) begin
            w_mack_nxt    = w_sda;
            w_bit_cnt_nxt = '0;
          end else if (w_fall && r_bit_cnt == 4'd0) begin
            if (r_mack == ACK) begin
              w_ptr_nxt    = w_ptr_inc;
              w_shift_nxt  = w_rd_nxt;
              w_sda_oe_nxt = ~w_rd_nxt[7];
              w_state_nxt  = S_RDATA;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = S_IGNORE;
            end
          end
        end
        S_IDLE, S_IGNORE: ;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Written from the registered strobe so the host sees the old value during the pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2**REG_AW; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else if (r_wr_valid) begin
      r_regs[r_wr_addr] <= r_wr_data;
    end
  end

  assign sda_oe          = r_sda_oe;
  assign busy            = r_busy;
  assign host.host_rdata = r_regs[host.host_addr];
  assign host.wr_valid   = r_wr_valid;
  assign host.wr_addr    = r_wr_addr;
  assign host.wr_data    = r_wr_data;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Self-checking bench: bit-banged I2C master against a register-file reference model.
module tb_i2c_target_regfile;
  import i2c_pkg::*;

  localparam int  AW = 8;
  localparam time Q  = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe, busy, sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_regfile_if #(.REG_AW(AW)) hif ();

  i2c_target_regfile #(
    .TARGET_ADDR (7'h08),
    .REG_AW      (AW),
    .RESET_VAL   (8'h00)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .scl_i  (scl_m),
    .sda_i  (sda_bus),
    .sda_oe (sda_oe),
    .busy   (busy),
    .host   (hif)
  );

  always #5 clk = ~clk;

  // Monitors: write log, host read around the write strobe, oe/busy activity
  logic [15:0] wr_log [1024];
  int   wr_count = 0;
  int   oe_hi_cnt = 0;
  int   busy_cnt = 0;
  int   oe_viol = 0;
  logic oe_prev = 1'b0;
  logic rd_pend = 1'b0;
  logic [7:0] rd_during = '0;
  logic [7:0] rd_after = '0;

  always @(negedge clk) begin
    if (hif.wr_valid) begin
      if (wr_count < 1024) wr_log[wr_count] = {hif.wr_addr, hif.wr_data};
      wr_count++;
      rd_during = hif.host_rdata;
      rd_pend = 1'b1;
    end else if (rd_pend) begin
      rd_after = hif.host_rdata;
      rd_pend = 1'b0;
    end
    if (sda_oe) oe_hi_cnt++;
    if (busy) busy_cnt++;
    if (!rst && sda_oe !== oe_prev && scl_m) oe_viol++;
    oe_prev = sda_oe;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [7:0]  mregs [256];
  logic [7:0]  mptr;
  logic [15:0] exp_q [$];
  int          wr_seen = 0;
  logic [7:0]  wbuf [8];

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
    mptr = 8'h00;
  endtask

  // Bit-level master
  task automatic bus_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic put_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
    end
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    put_bits(b, 8);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; ack = sda_bus; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b[i] = sda_bus; #Q; scl_m = 1'b0; #Q;
    end
    sda_m = mack; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  // Transactions
  task automatic tx_write(input logic [6:0] dev, input logic [7:0] ptr, input int n);
    logic a;
    logic exp_ack;
    exp_ack = (dev == 7'h08) ? ACK : NACK;
    bus_start();
    wr_byte({dev, RW_WRITE}, a); chk("dev_ack", a, exp_ack);
    wr_byte(ptr, a);             chk("reg_ack", a, exp_ack);
    if (dev == 7'h08) mptr = ptr;
    for (int i = 0; i < n; i++) begin
      wr_byte(wbuf[i], a); chk("wdata_ack", a, exp_ack);
      if (dev == 7'h08) begin
        mregs[mptr] = wbuf[i];
        exp_q.push_back({mptr, wbuf[i]});
        mptr = mptr + 8'd1;
      end
    end
    bus_stop();
  endtask

  task automatic read_seq(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      rd_byte((i == n - 1) ? NACK : ACK, b);
      chk("rd_data", b, mregs[mptr]);
      if (i != n - 1) mptr = mptr + 8'd1;
    end
    chk("rd_release", sda_oe, 1'b0);
  endtask

  task automatic tx_comb_read(input logic [7:0] ptr, input int n);
    logic a;
    bus_start();
    wr_byte({7'h08, RW_WRITE}, a); chk("cr_dev_ack", a, ACK);
    wr_byte(ptr, a);               chk("cr_reg_ack", a, ACK);
    mptr = ptr;
    bus_start();
    wr_byte({7'h08, RW_READ}, a);  chk("cr_rd_ack", a, ACK);
    read_seq(n);
    bus_stop();
  endtask

  task automatic tx_direct_read(input int n);
    logic a;
    bus_start();
    wr_byte({7'h08, RW_READ}, a); chk("dr_dev_ack", a, ACK);
    read_seq(n);
    bus_stop();
  endtask

  task automatic verify_wr();
    int got_n;
    repeat (2) @(negedge clk);
    got_n = wr_count - wr_seen;
    chk("wr_count", got_n, exp_q.size());
    for (int i = 0; i < got_n && i < exp_q.size() && wr_seen + i < 1024; i++)
      chk("wr_entry", wr_log[wr_seen + i], exp_q[i]);
    wr_seen = wr_count;
    exp_q.delete();
  endtask

  task automatic host_chk(input logic [7:0] addr, input logic [7:0] exp);
    hif.host_addr = addr;
    @(negedge clk);
    chk("host_rdata", hif.host_rdata, exp);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0, b0, n, op;
    logic a;
    logic [6:0] dev;
    logic [7:0] p, ha;

    hif.host_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_valid", hif.wr_valid, 1'b0);
    chk("rst_wr_addr", hif.wr_addr, 8'h00);
    chk("rst_wr_data", hif.wr_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    host_chk(8'h5A, 8'h00);

    // Wrong device address
    o0 = oe_hi_cnt; b0 = busy_cnt;
    wbuf[0] = 8'hAC;
    tx_write(7'h09, 8'h92, 1);
    verify_wr();
    chk("wrong_oe_cycles", oe_hi_cnt - o0, 0);
    chk("wrong_busy_cycles", busy_cnt - b0, 0);
    host_chk(8'h92, 8'h00);

    // Single write, host watching the written register
    hif.host_addr = 8'h92;
    b0 = busy_cnt;
    wbuf[0] = 8'hAC;
    tx_write(7'h08, 8'h92, 1);
    verify_wr();
    chk("t1_busy_seen", busy_cnt > b0, 1'b1);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_rd_during", rd_during, 8'h00);
    chk("t1_rd_after", rd_after, 8'hAC);
    host_chk(8'h92, 8'hAC);

    // Burst write wrapping the pointer
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    tx_write(7'h08, 8'hFF, 2);
    verify_wr();
    host_chk(8'hFF, 8'h11);
    host_chk(8'h00, 8'h22);

    wbuf[0] = 8'h3C;
    tx_write(7'h08, 8'h93, 1);
    verify_wr();

    // Combined read then direct read from the retained pointer
    tx_comb_read(8'h92, 2);
    tx_direct_read(1);

    // STOP mid data byte
    bus_start();
    wr_byte({7'h08, RW_WRITE}, a); chk("ab_dev_ack", a, ACK);
    wr_byte(8'h40, a);             chk("ab_reg_ack", a, ACK);
    mptr = 8'h40;
    put_bits(8'hE7, 4);
    bus_stop();
    verify_wr();
    host_chk(8'h40, 8'h00);

    // Reset while the target drives a read bit
    bus_start();
    wr_byte({7'h08, RW_READ}, a); chk("rr_dev_ack", a, ACK);
    for (int i = 0; i < 2; i++) begin
      sda_m = 1'b1; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
    end
    chk("rr_oe_before_rst", sda_oe, 1'b1);
    rst = 1'b1;
    #1;
    chk("rr_oe_async", sda_oe, 1'b0);
    chk("rr_busy_async", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus_stop();
    @(negedge clk);
    wbuf[0] = 8'h5A;
    tx_write(7'h08, 8'h05, 1);
    verify_wr();
    host_chk(8'h05, 8'h5A);
    tx_comb_read(8'h05, 1);

    // Randomized traffic
    for (int it = 0; it < 24; it++) begin
      op = int'($urandom_range(0, 3));
      p  = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      case (op)
        0: begin
          n = int'($urandom_range(1, 4));
          for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
          tx_write(7'h08, p, n);
        end
        1: tx_comb_read(p, int'($urandom_range(1, 3)));
        2: tx_direct_read(int'($urandom_range(1, 3)));
        default: begin
          dev = 7'($urandom_range(0, 127));
          if (dev == 7'h08) dev = 7'h09;
          wbuf[0] = 8'($urandom);
          tx_write(dev, p, 1);
        end
      endcase
      verify_wr();
      ha = 8'($urandom);
      host_chk(ha, mregs[ha]);
    end

    chk("oe_change_scl_high", oe_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
